// File: rtl/bcd_stopwatch_core.sv
// mm:ss BCD stopwatch/timer with built-in tick divider, preset load, terminal detect and error state.
// Optional lap-freeze display is enabled by defining LAP_HOLD_EN.
module bcd_stopwatch_core #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_MIN  = 59,
  parameter int unsigned SEC_MAX  = 59
) (
  input  logic        MAINCLOCK,
  input  logic        MAINPUSHR,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        mode,
  input  logic [15:0] preset,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        tick,
  output logic        running,
  output logic        done,
  output logic        err,
  output logic        lap_active
);

  localparam int unsigned    DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [7:0]     SEC_BCD  = 8'(((SEC_MAX / 10) << 4) | (SEC_MAX % 10));
  localparam logic [7:0]     MIN_BCD  = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));
  localparam logic [15:0]    TOP_BCD  = {MIN_BCD, SEC_BCD};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE, S_ERROR} state_t;

  state_t          state;
  logic [15:0]     cnt;
  logic [DW-1:0]   div;
  logic            mode_q;
  logic [15:0]     step_val;
  logic            terminal;
  logic            preset_ok;
  logic            wrap;
  logic [15:0]     live;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    step_val = cnt;
    if (mode_q) begin
      if (cnt[7:0] == 8'h00) step_val = {bcd_dec(cnt[15:8]), SEC_BCD};
      else                   step_val = {cnt[15:8], bcd_dec(cnt[7:0])};
    end else begin
      if (cnt[7:0] == SEC_BCD) step_val = {bcd_inc(cnt[15:8]), 8'h00};
      else                     step_val = {cnt[15:8], bcd_inc(cnt[7:0])};
    end
    terminal  = mode_q ? (step_val == 16'h0000) : (step_val == TOP_BCD);
    preset_ok = (preset[15:12] <= 4'd9) && (preset[11:8] <= 4'd9) &&
                (preset[7:4] <= 4'd9) && (preset[3:0] <= 4'd9) &&
                (preset[7:0] <= SEC_BCD) && (preset[15:8] <= MIN_BCD);
    wrap      = (div == DIV_LAST);
  end

  always_ff @(posedge MAINCLOCK or posedge MAINPUSHR) begin
    if (MAINPUSHR) begin
      state  <= S_IDLE;
      cnt    <= '0;
      div    <= '0;
      mode_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        div   <= '0;
        state <= S_IDLE;
      end else if (load) begin
        if (preset_ok) begin
          cnt   <= preset;
          div   <= '0;
          state <= S_IDLE;
        end else begin
          state <= S_ERROR;
        end
      end else begin
        case (state)
          S_IDLE: if (start_stop) begin
            mode_q <= mode;
            div    <= '0;
            // Already at the terminal value for the chosen direction: finish without stepping.
            if ((mode && cnt == 16'h0000) || (!mode && cnt == TOP_BCD)) state <= S_DONE;
            else                                                       state <= S_RUN;
          end
          S_RUN: begin
            if (start_stop) begin
              state <= S_PAUSE;
              // A wrap on the pausing edge is deferred so the step lands right after resume.
              if (!wrap) div <= div + DW'(1);
            end else if (wrap) begin
              div  <= '0;
              cnt  <= step_val;
              tick <= 1'b1;
              if (terminal) state <= S_DONE;
            end else begin
              div <= div + DW'(1);
            end
          end
          S_PAUSE: if (start_stop) state <= S_RUN;
          default: ;
        endcase
      end
    end
  end

`ifdef LAP_HOLD_EN
  logic        lap_q;
  logic [15:0] lap_cnt;

  always_ff @(posedge MAINCLOCK or posedge MAINPUSHR) begin
    if (MAINPUSHR) begin
      lap_q   <= 1'b0;
      lap_cnt <= '0;
    end else if (clear || load) begin
      lap_q <= 1'b0;
    end else if (lap && (state == S_RUN || state == S_PAUSE)) begin
      lap_q <= !lap_q;
      if (!lap_q) lap_cnt <= cnt;
    end
  end

  assign lap_active = lap_q;
  assign live       = lap_q ? lap_cnt : cnt;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_active = 1'b0;
  assign live       = cnt;
`endif

  assign digits  = (state == S_ERROR) ? 16'hEEEE : live;
  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign err     = (state == S_ERROR);

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Scoreboard bench for bcd_stopwatch_core: stimulus queues expected snapshots and per-tick digits,
// a negedge monitor pops and compares them.
module tb_bcd_stopwatch_core;

`ifdef LAP_HOLD_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif
  localparam int unsigned P_SS = 0, P_CLR = 1, P_LD = 2, P_LAP = 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ss = 1'b0, clr = 1'b0, ld = 1'b0, mode = 1'b0, lap = 1'b0;
  logic [15:0] preset = '0;
  logic [15:0] digits;
  logic        tick, running, done, err, lap_active;

  int unsigned n_tests = 0, n_fail = 0;
  logic        final_chk = 1'b0, final_done = 1'b0;

  typedef struct { string name; logic [19:0] exp; } snap_t;
  snap_t       snap_q[$];
  logic [15:0] tick_q[$];

  bcd_stopwatch_core #(.TICK_DIV(4), .MAX_MIN(59), .SEC_MAX(59)) dut (
    .MAINCLOCK (clk),
    .MAINPUSHR (rst),
    .start_stop(ss),
    .clear     (clr),
    .load      (ld),
    .mode      (mode),
    .preset    (preset),
    .lap       (lap),
    .digits    (digits),
    .tick      (tick),
    .running   (running),
    .done      (done),
    .err       (err),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_time(input int unsigned secs);
    int unsigned m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned k);
    case (k)
      P_SS:    ss  = 1'b1;
      P_CLR:   clr = 1'b1;
      P_LD:    ld  = 1'b1;
      default: lap = 1'b1;
    endcase
    cyc(1);
    ss = 1'b0; clr = 1'b0; ld = 1'b0; lap = 1'b0;
  endtask

  task automatic expect_snap(input string nm, input logic [15:0] d,
                             input logic r, input logic dn, input logic e, input logic l);
    snap_t s;
    s.name = nm;
    s.exp  = {d, r, dn, e, l};
    snap_q.push_back(s);
  endtask

  // Monitor: snapshots are compared at the first negedge after they are queued; every tick pops one digit value.
  always @(negedge clk) begin
    snap_t       s;
    logic [15:0] et;
    while (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      n_tests++;
      if ({digits, running, done, err, lap_active} !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got digits=%h run=%b done=%b err=%b lap=%b, want digits=%h run=%b done=%b err=%b lap=%b",
                 s.name, digits, running, done, err, lap_active,
                 s.exp[19:4], s.exp[3], s.exp[2], s.exp[1], s.exp[0]);
      end
    end
    if (tick) begin
      n_tests++;
      if (tick_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: got tick with digits=%h, want no tick", digits);
      end else begin
        et = tick_q.pop_front();
        if (digits !== et) begin
          n_fail++;
          $display("FAIL tick_digits: got %h want %h", digits, et);
        end
      end
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      n_tests++;
      if (tick_q.size() != 0) begin
        n_fail++;
        $display("FAIL ticks_outstanding: got %0d pending ticks want 0", tick_q.size());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    cyc(2);
    expect_snap("reset", 16'h0000, 0, 0, 0, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // 1: count up 10 steps in 40 cycles
    mode = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) tick_q.push_back(bcd_time(i));
    pulse(P_SS);
    expect_snap("t1_start", 16'h0000, 1, 0, 0, 0);
    cyc(40);
    expect_snap("t1_40cyc", 16'h0010, 1, 0, 0, 0);
    pulse(P_CLR);
    expect_snap("t1_clear", 16'h0000, 0, 0, 0, 0);

    // 2: terminal count up, no wrap
    preset = 16'h5958;
    pulse(P_LD);
    expect_snap("t2_load", 16'h5958, 0, 0, 0, 0);
    tick_q.push_back(16'h5959);
    pulse(P_SS);
    cyc(3);
    expect_snap("t2_pre_step", 16'h5958, 1, 0, 0, 0);
    cyc(1);
    expect_snap("t2_done", 16'h5959, 0, 1, 0, 0);
    cyc(8);
    expect_snap("t2_hold", 16'h5959, 0, 1, 0, 0);
    pulse(P_SS);
    expect_snap("t2_ss_ignored", 16'h5959, 0, 1, 0, 0);

    // 3: count down 01:00 -> 00:00
    preset = 16'h0100;
    pulse(P_LD);
    expect_snap("t3_load", 16'h0100, 0, 0, 0, 0);
    mode = 1'b1;
    for (int s = 59; s >= 0; s--) tick_q.push_back(bcd_time(32'(s)));
    pulse(P_SS);
    mode = 1'b0;
    cyc(4);
    expect_snap("t3_first", 16'h0059, 1, 0, 0, 0);
    cyc(235);
    expect_snap("t3_pre_end", 16'h0001, 1, 0, 0, 0);
    cyc(1);
    expect_snap("t3_done", 16'h0000, 0, 1, 0, 0);
    preset = 16'h0000;
    pulse(P_LD);
    mode = 1'b1;
    pulse(P_SS);
    mode = 1'b0;
    expect_snap("t3_down_from_zero", 16'h0000, 0, 1, 0, 0);
    cyc(6);

    // 4: invalid presets and recovery
    preset = 16'h0075;
    pulse(P_LD);
    expect_snap("t4_bad_secs", 16'hEEEE, 0, 0, 1, 0);
    pulse(P_SS);
    expect_snap("t4_ss_ignored", 16'hEEEE, 0, 0, 1, 0);
    preset = 16'h0A00;
    pulse(P_LD);
    expect_snap("t4_bad_nibble", 16'hEEEE, 0, 0, 1, 0);
    preset = 16'h6000;
    pulse(P_LD);
    expect_snap("t4_bad_mins", 16'hEEEE, 0, 0, 1, 0);
    preset = 16'h0030;
    pulse(P_LD);
    expect_snap("t4_recover", 16'h0030, 0, 0, 0, 0);

    // 5: pause keeps divider phase; load beats a coincident step
    pulse(P_CLR);
    tick_q.push_back(16'h0001);
    pulse(P_SS);
    cyc(5);
    pulse(P_SS);
    expect_snap("t5_paused", 16'h0001, 0, 0, 0, 0);
    cyc(20);
    expect_snap("t5_still_paused", 16'h0001, 0, 0, 0, 0);
    tick_q.push_back(16'h0002);
    pulse(P_SS);
    expect_snap("t5_resumed", 16'h0001, 1, 0, 0, 0);
    cyc(1);
    expect_snap("t5_resume_plus1", 16'h0001, 1, 0, 0, 0);
    cyc(1);
    expect_snap("t5_resume_step", 16'h0002, 1, 0, 0, 0);
    cyc(3);
    preset = 16'h0042;
    pulse(P_LD);
    expect_snap("t5_load_vs_step", 16'h0042, 0, 0, 0, 0);
    cyc(6);
    expect_snap("t5_no_extra", 16'h0042, 0, 0, 0, 0);

    // 6: lap freeze (or ignored lap) and asynchronous reset mid-run
    pulse(P_CLR);
    tick_q.push_back(16'h0001);
    tick_q.push_back(16'h0002);
    tick_q.push_back(16'h0003);
    tick_q.push_back(LAP ? 16'h0003 : 16'h0004);
    tick_q.push_back(LAP ? 16'h0003 : 16'h0005);
    pulse(P_SS);
    cyc(12);
    pulse(P_LAP);
    expect_snap("t6_lap_on", 16'h0003, 1, 0, 0, LAP);
    cyc(8);
    expect_snap("t6_frozen", LAP ? 16'h0003 : 16'h0005, 1, 0, 0, LAP);
    pulse(P_LAP);
    expect_snap("t6_lap_off", 16'h0005, 1, 0, 0, 0);
    cyc(1);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    expect_snap("t6_async_reset", 16'h0000, 0, 0, 0, 0);

    // 7: clean restart after reset, first step exactly TICK_DIV cycles later
    cyc(1);
    tick_q.push_back(16'h0001);
    pulse(P_SS);
    cyc(3);
    expect_snap("t7_pre_step", 16'h0000, 1, 0, 0, 0);
    cyc(1);
    expect_snap("t7_step", 16'h0001, 1, 0, 0, 0);
    pulse(P_CLR);
    cyc(2);
    final_chk = 1'b1;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
